alien_rocket_launcher: RTL and testbench



---
 rtl/alien_rocket_launcher_pkg.sv | 23 ++
 rtl/alien_rocket_launcher_if.sv | 31 +++
 rtl/alien_rocket_launcher_rocket_slot.sv | 127 ++++++++++++
 rtl/alien_rocket_launcher.sv | 105 ++++++++++
 tb/tb_alien_rocket_launcher.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alien_rocket_launcher_pkg.sv
// Shared types and screen constants for the alien rocket launcher.
// Optional feature macro used by the design: ROCKET_HOMING_EN.
package alien_rocket_pkg;

    // 640x480 visible area.
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int SCREEN_BOTTOM = 479;

    typedef logic [10:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        HIT    = 2'd2
    } rocket_state_t;

    // Widen a screen coordinate so sums near the screen edge cannot wrap.
    function automatic logic [11:0] ext12(input coord_t v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/alien_rocket_launcher_if.sv
// Launch handshake between the alien-grid shooter selector (master) and
// the rocket launcher (slave).
//
// Handshake: launchValid/launchX/launchY are held by the master while it
// has a candidate. launchAck is a one-cycle pulse from the slave meaning
// "this candidate was taken this cycle"; it can only rise in a cycle with
// startOfFrame high. A candidate without an ack is simply not taken and
// the master may keep or change it.
interface alien_rocket_launcher_if;
    import alien_rocket_pkg::*;

    logic   launchValid;
    coord_t launchX;
    coord_t launchY;
    logic   launchAck;

    modport master (
        output launchValid,
        output launchX,
        output launchY,
        input  launchAck
    );

    modport slave (
        input  launchValid,
        input  launchX,
        input  launchY,
        output launchAck
    );

endinterface

// File: rtl/alien_rocket_launcher_rocket_slot.sv
// One rocket slot: IDLE/FLYING/HIT state machine, position, registered
// pixel-cover test and the sticky per-frame hit bit.
// With ROCKET_HOMING_EN defined, x steps one pixel per frame toward player_x_i.
module rocket_slot
    import alien_rocket_pkg::*;
#(
    parameter int ROCKET_W      = 4,
    parameter int ROCKET_H      = 12,
    parameter int ROCKET_SPEED  = 4,
    parameter int BOTTOM_Y      = SCREEN_BOTTOM
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_of_frame,
    input  logic          launch_i,
    input  coord_t        launch_x_i,
    input  coord_t        launch_y_i,
    input  coord_t        pixel_x_i,
    input  coord_t        pixel_y_i,
    input  logic          player_draw_i,
`ifdef ROCKET_HOMING_EN
    input  coord_t        player_x_i,
`endif
    output logic          draw_o,
    output logic          hit_o,
    output logic          active_o,
    output rocket_state_t state_o
);

    rocket_state_t state_q, state_d;
    coord_t        x_q, x_d;
    coord_t        y_q, y_d;
    logic          cover_q, cover_d;
    logic          hit_q, hit_d;

    logic [11:0]   y_moved;
    logic [11:0]   launch_y_ext;
    logic          in_x;
    logic          in_y;
    logic          collide;

    // Cover test, collision detect and next-state/coordinate update.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        hit_d        = hit_q;

        y_moved      = ext12(y_q) + 12'(ROCKET_SPEED);
        launch_y_ext = ext12(launch_y_i) + 12'(ROCKET_H);

        in_x    = (ext12(pixel_x_i) >= ext12(x_q)) &&
                  (ext12(pixel_x_i) <  ext12(x_q) + 12'(ROCKET_W));
        in_y    = (ext12(pixel_y_i) >= ext12(y_q)) &&
                  (ext12(pixel_y_i) <  ext12(y_q) + 12'(ROCKET_H));
        cover_d = (state_q == FLYING) && in_x && in_y;

        // cover_q belongs to the pixel the player request is aligned with.
        collide = cover_q && (state_q == FLYING) && player_draw_i;

        case (state_q)
            IDLE: begin
                hit_d = 1'b0;
                if (launch_i) begin
                    state_d = FLYING;
                    x_d     = launch_x_i;
                    y_d     = launch_y_ext[10:0];
                end
            end
            FLYING: begin
                // A collision beats a coincident frame step: no move.
                if (collide) begin
                    state_d = HIT;
                    hit_d   = 1'b1;
                end else if (start_of_frame) begin
                    if (y_moved >= 12'(BOTTOM_Y)) begin
                        state_d = IDLE;
                    end else begin
                        y_d = y_moved[10:0];
`ifdef ROCKET_HOMING_EN
                        if (x_q < player_x_i) begin
                            x_d = x_q + 11'd1;
                        end else if (x_q > player_x_i) begin
                            x_d = x_q - 11'd1;
                        end
`endif
                    end
                end
            end
            HIT: begin
                if (start_of_frame) begin
                    state_d = IDLE;
                    hit_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                hit_d   = 1'b0;
            end
        endcase
    end

    // Slot state, position, cover and hit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cover_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cover_q <= cover_d;
            hit_q   <= hit_d;
        end
    end

    // Only a slot still flying is drawn; this also masks the stale cover
    // bit in the cycle the slot turns HIT.
    assign draw_o   = cover_q && (state_q == FLYING);
    assign hit_o    = hit_q;
    assign active_o = (state_q != IDLE);
    assign state_o  = state_q;

endmodule

// File: rtl/alien_rocket_launcher.sv
// Alien rocket launcher: NUM_ROCKETS rocket slots, a lowest-free-slot launch
// arbiter and a frame cooldown between launches.
// Optional feature macro: ROCKET_HOMING_EN (adds playerX; rockets drift
// one pixel per frame toward it).
module alien_rocket_launcher
    import alien_rocket_pkg::*;
#(
    parameter int NUM_ROCKETS     = 3,
    parameter int ROCKET_W        = 4,
    parameter int ROCKET_H        = 12,
    parameter int ROCKET_SPEED    = 4,
    parameter int BOTTOM_Y        = SCREEN_BOTTOM,
    parameter int COOLDOWN_FRAMES = 40
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  coord_t                   pixelX,
    input  coord_t                   pixelY,
    input  logic                     playerDrawingRequest,
`ifdef ROCKET_HOMING_EN
    input  coord_t                   playerX,
`endif
    alien_rocket_launcher_if.slave   launch_if,
    output logic                     rocketDrawingRequest,
    output logic [NUM_ROCKETS-1:0]   playerHitByRocket,
    output logic [NUM_ROCKETS-1:0]   activeRockets
);

    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

    logic [CD_W-1:0]        cooldown_q, cooldown_d;
    logic [NUM_ROCKETS-1:0] idle_vec;
    logic [NUM_ROCKETS-1:0] launch_sel;
    logic [NUM_ROCKETS-1:0] draw_vec;
    logic                   launch_fire;
    logic                   slot_found;
    rocket_state_t          slot_state [NUM_ROCKETS];

    // Lowest-index idle slot; a launch is fired only when every condition
    // holds in the same startOfFrame cycle (and never while in reset).
    always_comb begin
        launch_sel = '0;
        slot_found = 1'b0;
        for (int i = 0; i < NUM_ROCKETS; i++) begin
            if (idle_vec[i] && !slot_found) begin
                launch_sel[i] = 1'b1;
                slot_found    = 1'b1;
            end
        end
        launch_fire = resetN && startOfFrame && launch_if.launchValid &&
                      (cooldown_q == '0) && slot_found;
    end

    // Cooldown: reload on launch, otherwise count frames down to zero.
    always_comb begin
        cooldown_d = cooldown_q;
        if (launch_fire) begin
            cooldown_d = CD_W'(COOLDOWN_FRAMES);
        end else if (startOfFrame && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end
    end

    // Cooldown register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cooldown_q <= '0;
        end else begin
            cooldown_q <= cooldown_d;
        end
    end

    for (genvar g = 0; g < NUM_ROCKETS; g++) begin : g_slot
        rocket_slot #(
            .ROCKET_W     (ROCKET_W),
            .ROCKET_H     (ROCKET_H),
            .ROCKET_SPEED (ROCKET_SPEED),
            .BOTTOM_Y     (BOTTOM_Y)
        ) u_slot (
            .clk            (clk),
            .rst_n          (resetN),
            .start_of_frame (startOfFrame),
            .launch_i       (launch_fire && launch_sel[g]),
            .launch_x_i     (launch_if.launchX),
            .launch_y_i     (launch_if.launchY),
            .pixel_x_i      (pixelX),
            .pixel_y_i      (pixelY),
            .player_draw_i  (playerDrawingRequest),
`ifdef ROCKET_HOMING_EN
            .player_x_i     (playerX),
`endif
            .draw_o         (draw_vec[g]),
            .hit_o          (playerHitByRocket[g]),
            .active_o       (activeRockets[g]),
            .state_o        (slot_state[g])
        );

        assign idle_vec[g] = (slot_state[g] == IDLE);
    end

    assign launch_if.launchAck = launch_fire;
    assign rocketDrawingRequest = |draw_vec;

endmodule

// File: tb/tb_alien_rocket_launcher.sv
// Directed bench for alien_rocket_launcher: launch, movement, drawing
// window, cooldown, hit, retirement, async reset and (optionally) homing.
module tb_alien_rocket_launcher;
    import alien_rocket_pkg::*;

    logic   clk = 1'b0;
    logic   resetN;
    logic   startOfFrame;
    coord_t pixelX;
    coord_t pixelY;
    logic   playerDrawingRequest;
`ifdef ROCKET_HOMING_EN
    coord_t playerX;
`endif
    logic       rocketDrawingRequest;
    logic [2:0] playerHitByRocket;
    logic [2:0] activeRockets;

    alien_rocket_launcher_if lif ();

    alien_rocket_launcher dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .pixelX               (pixelX),
        .pixelY               (pixelY),
        .playerDrawingRequest (playerDrawingRequest),
`ifdef ROCKET_HOMING_EN
        .playerX              (playerX),
`endif
        .launch_if            (lif),
        .rocketDrawingRequest (rocketDrawingRequest),
        .playerHitByRocket    (playerHitByRocket),
        .activeRockets        (activeRockets)
    );

    // Clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: startOfFrame high for one cycle, ack sampled before the edge.
    task automatic sof_pulse(output logic ack);
        startOfFrame = 1'b1;
        #1;
        ack = lif.launchAck;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        frame_no++;
        @(posedge clk);
        #1;
    endtask

    // Present a pixel and read the registered drawing request one cycle later.
    task automatic probe(input int x, input int y, output logic r);
        pixelX = 11'(x);
        pixelY = 11'(y);
        @(posedge clk);
        #1;
        r = rocketDrawingRequest;
    endtask

    int   px_tab [7] = '{100, 103,  99, 104, 101, 101, 102};
    int   py_tab [7] = '{ 74,  85,  80,  80,  73,  86,  79};
    logic dr_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic ack;
        logic r;
        int   f;

        resetN               = 1'b0;
        startOfFrame         = 1'b0;
        pixelX               = '0;
        pixelY               = '0;
        playerDrawingRequest = 1'b0;
        lif.launchValid      = 1'b0;
        lif.launchX          = '0;
        lif.launchY          = '0;
`ifdef ROCKET_HOMING_EN
        playerX              = 11'd100;
`endif
        repeat (3) @(posedge clk);
        #1;

        // Reset state, with a would-be launch presented during reset.
        startOfFrame    = 1'b1;
        lif.launchValid = 1'b1;
        #1;
        check_eq("rst_ack", lif.launchAck, 0);
        check_eq("rst_active", activeRockets, 0);
        check_eq("rst_hit", playerHitByRocket, 0);
        check_eq("rst_draw", rocketDrawingRequest, 0);
        startOfFrame    = 1'b0;
        lif.launchValid = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // First launch at frame 0.
        lif.launchValid = 1'b1;
        lif.launchX     = 11'd100;
        lif.launchY     = 11'd50;
        sof_pulse(ack);
        check_eq("launch_ack", ack, 1);
        check_eq("launch_active", activeRockets, 3'b001);
        check_eq("launch_x", dut.g_slot[0].u_slot.x_q, 100);
        check_eq("launch_y", dut.g_slot[0].u_slot.y_q, 62);

        // Three frames of movement, no ack while cooling down.
        for (int i = 0; i < 3; i++) begin
            sof_pulse(ack);
            check_eq("cool_ack", ack, 0);
        end
        check_eq("move_y", dut.g_slot[0].u_slot.y_q, 74);

        // Drawing window 100..103 x 74..85.
        for (int i = 0; i < 7; i++) begin
            probe(px_tab[i], py_tab[i], r);
            check_eq($sformatf("draw_%0d_%0d", px_tab[i], py_tab[i]), r, dr_tab[i]);
        end

        // Hit at (101,80).
        probe(101, 80, r);
        check_eq("hit_cover", r, 1);
        playerDrawingRequest = 1'b1;
        @(posedge clk);
        #1;
        playerDrawingRequest = 1'b0;
        check_eq("hit_bit", playerHitByRocket, 3'b001);
        check_eq("hit_active", activeRockets, 3'b001);
        check_eq("hit_nodraw", rocketDrawingRequest, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hit_hold", playerHitByRocket, 3'b001);
        sof_pulse(ack);
        check_eq("hit_sof_ack", ack, 0);
        check_eq("hit_clear", playerHitByRocket, 0);
        check_eq("hit_idle", activeRockets, 0);

        // Cooldown spacing: launches held valid from frame 4 on.
        lif.launchX = 11'd200;
        lif.launchY = 11'd0;
`ifdef ROCKET_HOMING_EN
        playerX     = 11'd200;
`endif
        exp_q.push_back(41);
        exp_q.push_back(82);
        exp_q.push_back(123);
        while (frame_no <= 123) begin
            f = frame_no;
            sof_pulse(ack);
            if (ack) begin
                if (exp_q.size() == 0) check_eq("extra_ack", f, 0);
                else check_eq("ack_frame", f, exp_q.pop_front());
            end
        end
        check_eq("acks_missing", exp_q.size(), 0);
        check_eq("three_active", activeRockets, 3'b111);
        sof_pulse(ack);
        check_eq("full_noack", ack, 0);
        lif.launchValid = 1'b0;

        // Retirement: slot0 reaches y=476 at frame 157, retires at 158.
        while (frame_no <= 157) sof_pulse(ack);
        check_eq("pre_retire_y", dut.g_slot[0].u_slot.y_q, 476);
        check_eq("pre_retire_act", activeRockets, 3'b111);
        sof_pulse(ack);
        check_eq("retire_act", activeRockets, 3'b110);
        check_eq("retire_hit", playerHitByRocket, 0);
        check_eq("slot2_y", dut.g_slot[2].u_slot.y_q, 152);

        // Hit slot2 at (201,160), then async reset mid-flight.
        probe(201, 160, r);
        check_eq("slot2_cover", r, 1);
        playerDrawingRequest = 1'b1;
        @(posedge clk);
        #1;
        playerDrawingRequest = 1'b0;
        check_eq("slot2_hit", playerHitByRocket, 3'b100);
        check_eq("slot2_active", activeRockets, 3'b110);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("async_active", activeRockets, 0);
        check_eq("async_hit", playerHitByRocket, 0);
        check_eq("async_draw", rocketDrawingRequest, 0);

`ifdef ROCKET_HOMING_EN
        @(posedge clk);
        #1;
        resetN          = 1'b1;
        playerX         = 11'd110;
        lif.launchValid = 1'b1;
        lif.launchX     = 11'd100;
        lif.launchY     = 11'd50;
        sof_pulse(ack);
        check_eq("home_ack", ack, 1);
        lif.launchValid = 1'b0;
        sof_pulse(ack);
        check_eq("home_x", dut.g_slot[0].u_slot.x_q, 101);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
